ifu_prefetch: RTL

Instruction fetch unit with a prefetch queue. It issues in-order requests to the instruction memory bus and buffers returned instructions, tagged with their PC, in a DEPTH-entry FIFO. It presents one instruction per cycle to the if_id pipeline register. It honours the pipeline-wide load_hazerd stall and the branch/jalr redirect (flush_flag/flush_addr) raised by the execute stage.

---
 rtl/ifu_prefetch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: in-order instruction fetch with a credit-limited prefetch FIFO.
// Returned words are tagged with their PC and presented one per cycle to if_id;
// load_hazerd holds the head, flush_flag redirects fetch and discards stale data.
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_flag,
    input  logic [XLEN-1:0] flush_addr,
    input  logic            load_hazerd,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    output logic            inst_valid
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] respPc_q, respPc_d;
    logic [CW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [XLEN-1:0] fifoPc_q    [DEPTH];
    logic [31:0]     fifoInstr_q [DEPTH];

    logic [CW-1:0]   occupancy;
    logic [CW:0]     inUse;
    logic            fifoEmpty;
    logic [AW-1:0]   headIdx;
    logic [XLEN-1:0] flushTarget;
    logic            grant;
    logic            respValid;
    logic            keepResp;
    logic            pop;

    assign occupancy   = wrPtr_q - rdPtr_q;
    assign inUse       = {1'b0, occupancy} + {1'b0, outstanding_q};
    assign fifoEmpty   = (wrPtr_q == rdPtr_q);
    assign headIdx     = rdPtr_q[AW-1:0];
    assign flushTarget = flush_addr & ~XLEN'(3);
    assign grant       = imem_req && imem_gnt;
    assign respValid   = imem_rvalid && (outstanding_q != '0);
    assign keepResp    = respValid && (discard_q == '0) && !flush_flag;
    assign pop         = inst_valid && !load_hazerd;

    // Bus request and if_id presentation, derived from current state and credits
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = fetchPc_q;
        inst_valid  = 1'b0;
        pc          = respPc_q;
        instruction = NOP;
        if ((state_q != IDLE) && (inUse < DEPTH_W) && !flush_flag) begin
            imem_req = 1'b1;
        end
        if (!fifoEmpty) begin
            pc = fifoPc_q[headIdx];
            if (!flush_flag) begin
                inst_valid  = 1'b1;
                instruction = fifoInstr_q[headIdx];
            end
        end
    end

    // Next-state: counters, pointers, PCs and the IDLE/RUN/DRAIN sequencing
    always_comb begin
        state_d       = state_q;
        fetchPc_d     = fetchPc_q;
        respPc_d      = respPc_q;
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (grant) begin
            outstanding_d = outstanding_d + CW'(1);
        end
        if (respValid) begin
            outstanding_d = outstanding_d - CW'(1);
        end

        if (flush_flag) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            fetchPc_d = flushTarget;
            respPc_d  = flushTarget;
            discard_d = outstanding_d;
        end else begin
            if (grant) begin
                fetchPc_d = fetchPc_q + XLEN'(4);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + CW'(1);
            end
            if (respValid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    wrPtr_d  = wrPtr_q + CW'(1);
                    respPc_d = respPc_q + XLEN'(4);
                end
            end
        end

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (discard_d != '0) state_d = DRAIN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetchPc_q     <= RESET_PC;
            respPc_q      <= RESET_PC;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetchPc_q     <= fetchPc_d;
            respPc_q      <= respPc_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // FIFO storage: capture each kept response tagged with its expected PC
    always_ff @(posedge clk) begin
        if (rst && keepResp) begin
            fifoPc_q[wrPtr_q[AW-1:0]]    <= respPc_q;
            fifoInstr_q[wrPtr_q[AW-1:0]] <= imem_rdata;
        end
    end

endmodule
